write_buf_ctl: RTL and testbench
================================

# write_buf_ctl

Write-side buffer controller for the memory datapath: accepts single-beat client writes, holds up to DEPTH pending address/data pairs in order, and drains them to the RAM write port under a valid/acknowledge handshake. It sits between the client write interface and the RAM. It is the write-direction counterpart of the read-buffer counter and exposes the same style of occupancy count and full flag to the client.

## Interface
Parameters:
- AW, 16: address width
- DW, 32: data width
- DEPTH, 2: buffer entries; power of two, at least 2
- CW, $clog2(DEPTH)+1: width of the occupancy count (derived; do not override)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_L  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- we  in  1  client write request; accepted only when wb_full is 0
- waddr  in  AW  client write address; sampled on accept
- wdata  in  DW  client write data; sampled on accept
- wb_cnt  out  CW  number of valid entries, 0..DEPTH
- wb_full  out  1  wb_cnt == DEPTH
- wb_empty  out  1  wb_cnt == 0
- ram_we  out  1  RAM write valid; head entry is presented
- ram_addr  out  AW  head entry address
- ram_wdata  out  DW  head entry data
- ram_ack  in  1  RAM accepted the presented write this cycle
- wb_ovf  out  1  sticky overflow flag (only with WRITE_BUF_OVF_CHK_EN)

## Operation
- push = we & ~wb_full; pop = ram_we & ram_ack.
- State machine (wb_state_t): WB_EMPTY, WB_ACTIVE (0 < cnt < DEPTH), WB_FULL.
  - WB_EMPTY: push goes to WB_ACTIVE. The pop condition is impossible because ram_we is 0.
  - WB_ACTIVE: push without pop increments the count and goes to WB_FULL if cnt+1 == DEPTH. Pop without push decrements the count and goes to WB_EMPTY if cnt == 1. Push with pop holds the count and the state.
  - WB_FULL: pop decrements the count and goes to WB_ACTIVE. A write attempted with we while full is not accepted and has no effect on state.
- Storage is a circular buffer with write and read pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH with natural overflow.
- Push writes waddr/wdata at the write pointer, then increments it. Pop increments the read pointer.
- ram_we = ~wb_empty. ram_addr and ram_wdata always show the entry at the read pointer.
- ram_we, ram_addr and ram_wdata stay stable until ram_ack is sampled high.
- ram_ack while ram_we is 0 is ignored.
- Ordering: RAM writes are issued strictly in client accept order. There is no merging and no reordering.

## Timing
- Reset values: wb_cnt=0, wb_empty=1, wb_full=0, ram_we=0, wb_ovf=0, pointers=0, state=WB_EMPTY. ram_addr and ram_wdata are don't-care while ram_we is 0.
- An asserted RST_L mid-operation discards all pending entries immediately. It does not wait for a clock edge.
- Latency: a write accepted at edge N is presented on ram_we after edge N, in cycle N+1, if the buffer was empty. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle. This gives sustained full rate when ram_ack is held at 1.
- Simultaneous push and pop when full is impossible, because push requires ~wb_full. The client sees wb_full drop one cycle after the pop.
- wb_cnt, wb_full and wb_empty are registered or decoded from registers only. They have no combinational path from we or ram_ack.

## Configuration
- WRITE_BUF_OVF_CHK_EN defined:
  - wb_ovf is present.
  - wb_ovf sets on any cycle with we & wb_full.
  - wb_ovf clears only on reset.
  - An SVA assertion fires on the same condition.
- WRITE_BUF_OVF_CHK_EN undefined:
  - the wb_ovf port is absent.
  - A write while full is silently dropped.

## Structure
- Package write_buf_pkg holds:
  - wb_state_t enum (WB_EMPTY, WB_ACTIVE, WB_FULL)
  - default AW/DW/DEPTH localparams
- Sub-module wb_store: the DEPTH x (AW+DW) register array. It has a write port (index, enable, data) and an asynchronous read at the read index.
- The control FSM, pointers and count live in write_buf_ctl.

## Test plan
- Reset, then idle: wb_cnt=0, wb_empty=1, ram_we=0; ram_ack pulses change nothing.
- Single write of addr 0x0010/data 0xA5A5A5A5 with ram_ack=0: ram_we=1 with that addr/data from the next cycle; held 5 cycles. Raise ram_ack: after that edge wb_cnt=0 and ram_we=0.
- Fill with ram_ack=0 (addr 0x1, 0x2): wb_full=1 and wb_cnt=2. A third we (addr 0x3) is dropped; wb_ovf=1 if WRITE_BUF_OVF_CHK_EN. Drain: RAM sees 0x1 then 0x2 only.
- Streaming 8 writes with ram_ack held at 1: count never exceeds 1, pointers wrap, and RAM receives all 8 in order at one per cycle.
- Push and pop in the same cycle at wb_cnt=1: wb_cnt stays 1 and the head advances to the newer entry.
- Assert RST_L low with 2 pending entries, between clock edges: ram_we and wb_cnt drop to 0 immediately. After release, a new write drains normally.

Source files
------------

// File: rtl/write_buf_pkg.sv
// Shared types and default sizing for the write buffer controller.
// Optional overflow tracking is enabled with WRITE_BUF_OVF_CHK_EN.
package write_buf_pkg;

  localparam int WB_AW    = 16;
  localparam int WB_DW    = 32;
  localparam int WB_DEPTH = 2;

  typedef enum logic [1:0] {
    WB_EMPTY  = 2'd0,
    WB_ACTIVE = 2'd1,
    WB_FULL   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/write_buf_ctl_if.sv
// Client write + RAM write-port bundle for write_buf_ctl.
// wb_ovf exists only when WRITE_BUF_OVF_CHK_EN is defined.
interface write_buf_ctl_if #(
  parameter  int AW    = 16,
  parameter  int DW    = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
);

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [CW-1:0] wb_cnt;
  logic          wb_full;
  logic          wb_empty;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_ack;
`ifdef WRITE_BUF_OVF_CHK_EN
  logic          wb_ovf;
`endif

`ifdef WRITE_BUF_OVF_CHK_EN
  modport slave (
    input  we, waddr, wdata, ram_ack,
    output wb_cnt, wb_full, wb_empty,
    output ram_we, ram_addr, ram_wdata,
    output wb_ovf
  );

  modport master (
    output we, waddr, wdata, ram_ack,
    input  wb_cnt, wb_full, wb_empty,
    input  ram_we, ram_addr, ram_wdata,
    input  wb_ovf
  );
`else
  modport slave (
    input  we, waddr, wdata, ram_ack,
    output wb_cnt, wb_full, wb_empty,
    output ram_we, ram_addr, ram_wdata
  );

  modport master (
    output we, waddr, wdata, ram_ack,
    input  wb_cnt, wb_full, wb_empty,
    input  ram_we, ram_addr, ram_wdata
  );
`endif

endinterface

// File: rtl/wb_store.sv
// DEPTH x W entry array: one synchronous write port,
// asynchronous read at the read index.
module wb_store #(
  parameter  int DEPTH = 2,
  parameter  int W     = 48,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [PW-1:0] widx_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [PW-1:0] ridx_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/write_buf_ctl.sv
// In-order write buffer between client writes and the RAM write port.
// Define WRITE_BUF_OVF_CHK_EN for the sticky wb_ovf flag and its assertion.
module write_buf_ctl
  import write_buf_pkg::*;
#(
  parameter  int AW    = WB_AW,
  parameter  int DW    = WB_DW,
  parameter  int DEPTH = WB_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic CLK,
  input  logic RST_L,
  write_buf_ctl_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  wb_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;

  logic             wb_full;
  logic             wb_empty;
  logic             push;
  logic             pop;
  logic [AW+DW-1:0] head;

  // Flags decode from the count register only.
  assign wb_full  = (cnt_q == CNT_FULL);
  assign wb_empty = (cnt_q == '0);

  assign push = bus.we & ~wb_full;
  assign pop  = ~wb_empty & bus.ram_ack;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q <= WB_EMPTY;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;

    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end

    unique case (state_q)
      WB_EMPTY: begin
        if (push) begin
          cnt_d   = CNT_ONE;
          state_d = WB_ACTIVE;
        end
      end
      WB_ACTIVE: begin
        if (push && !pop) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = WB_FULL;
          end
        end else if (pop && !push) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = WB_EMPTY;
          end
        end
      end
      WB_FULL: begin
        if (pop) begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = WB_ACTIVE;
        end
      end
      default: begin
        state_d = WB_EMPTY;
      end
    endcase
  end

  wb_store #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_store (
    .clk_i   (CLK),
    .rst_ni  (RST_L),
    .we_i    (push),
    .widx_i  (wptr_q),
    .wdata_i ({bus.waddr, bus.wdata}),
    .ridx_i  (rptr_q),
    .rdata_o (head)
  );

  assign bus.wb_cnt    = cnt_q;
  assign bus.wb_full   = wb_full;
  assign bus.wb_empty  = wb_empty;
  assign bus.ram_we    = ~wb_empty;
  assign bus.ram_addr  = head[AW+DW-1:DW];
  assign bus.ram_wdata = head[DW-1:0];

`ifdef WRITE_BUF_OVF_CHK_EN
  logic ovf_q;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      ovf_q <= 1'b0;
    end else if (bus.we && wb_full) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.wb_ovf = ovf_q;

  a_no_write_when_full: assert property (
    @(posedge CLK) disable iff (!RST_L)
    !(bus.we && wb_full)
  );
`endif

endmodule

// File: tb/tb_write_buf_ctl.sv
// Directed bench for write_buf_ctl: reset, hold, fill/drop,
// streaming, same-cycle push/pop and mid-run async reset.
module tb_write_buf_ctl;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic CLK;
  logic RST_L;

  int n_chk;
  int n_fail;

  write_buf_ctl_if #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) bus ();

  write_buf_ctl #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .CLK   (CLK),
    .RST_L (RST_L),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    RST_L       = 1'b0;
    bus.we      = 1'b0;
    bus.waddr   = '0;
    bus.wdata   = '0;
    bus.ram_ack = 1'b0;

    tick();
    tick();
    chk("rst_cnt", 64'(bus.wb_cnt), 64'd0);
    chk("rst_empty", 64'(bus.wb_empty), 64'd1);
    chk("rst_full", 64'(bus.wb_full), 64'd0);
    chk("rst_ramwe", 64'(bus.ram_we), 64'd0);
`ifdef WRITE_BUF_OVF_CHK_EN
    chk("rst_ovf", 64'(bus.wb_ovf), 64'd0);
`endif
    RST_L = 1'b1;
    tick();

    // Idle ack pulse is ignored.
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    tick();
    chk("idle_cnt", 64'(bus.wb_cnt), 64'd0);
    chk("idle_ramwe", 64'(bus.ram_we), 64'd0);

    // Single write, no bypass, held while unacked.
    bus.we    = 1'b1;
    bus.waddr = 16'h0010;
    bus.wdata = 32'hA5A5_A5A5;
    #1;
    chk("nobypass", 64'(bus.ram_we), 64'd0);
    tick();
    bus.we = 1'b0;
    chk("single_we", 64'(bus.ram_we), 64'd1);
    chk("single_cnt", 64'(bus.wb_cnt), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_we", 64'(bus.ram_we), 64'd1);
      chk("hold_addr", 64'(bus.ram_addr), 64'h0010);
      chk("hold_data", 64'(bus.ram_wdata), 64'hA5A5_A5A5);
    end
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    chk("single_done_cnt", 64'(bus.wb_cnt), 64'd0);
    chk("single_done_we", 64'(bus.ram_we), 64'd0);
    chk("single_done_empty", 64'(bus.wb_empty), 64'd1);

    // Fill, then a dropped third write.
    bus.we    = 1'b1;
    bus.waddr = 16'h0001;
    bus.wdata = 32'h0000_0011;
    tick();
    bus.waddr = 16'h0002;
    bus.wdata = 32'h0000_0022;
    tick();
    chk("fill_full", 64'(bus.wb_full), 64'd1);
    chk("fill_cnt", 64'(bus.wb_cnt), 64'd2);
    bus.waddr = 16'h0003;
    bus.wdata = 32'h0000_0033;
    tick();
    bus.we = 1'b0;
    chk("drop_cnt", 64'(bus.wb_cnt), 64'd2);
    chk("drop_head", 64'(bus.ram_addr), 64'h0001);
`ifdef WRITE_BUF_OVF_CHK_EN
    chk("drop_ovf", 64'(bus.wb_ovf), 64'd1);
`endif
    bus.ram_ack = 1'b1;
    #1;
    chk("drain0_addr", 64'(bus.ram_addr), 64'h0001);
    chk("drain0_data", 64'(bus.ram_wdata), 64'h11);
    tick();
    chk("drain1_addr", 64'(bus.ram_addr), 64'h0002);
    chk("drain1_data", 64'(bus.ram_wdata), 64'h22);
    chk("drain1_full", 64'(bus.wb_full), 64'd0);
    chk("drain1_cnt", 64'(bus.wb_cnt), 64'd1);
    tick();
    bus.ram_ack = 1'b0;
    chk("drain2_cnt", 64'(bus.wb_cnt), 64'd0);
    chk("drain2_we", 64'(bus.ram_we), 64'd0);

    // Streaming with ack held high; pointers wrap.
    bus.ram_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.we    = 1'b1;
      bus.waddr = 16'h0100 + 16'(i);
      bus.wdata = 32'hC000_0000 + 32'(i);
      tick();
      chk("strm_we", 64'(bus.ram_we), 64'd1);
      chk("strm_cnt", 64'(bus.wb_cnt), 64'd1);
      chk("strm_addr", 64'(bus.ram_addr),
          64'h0100 + 64'(i));
      chk("strm_data", 64'(bus.ram_wdata),
          64'hC000_0000 + 64'(i));
    end
    bus.we = 1'b0;
    tick();
    bus.ram_ack = 1'b0;
    chk("strm_end_cnt", 64'(bus.wb_cnt), 64'd0);

    // Push and pop together at cnt 1.
    bus.we    = 1'b1;
    bus.waddr = 16'h0200;
    bus.wdata = 32'h2000_0000;
    tick();
    chk("pp_cnt0", 64'(bus.wb_cnt), 64'd1);
    chk("pp_head0", 64'(bus.ram_addr), 64'h0200);
    bus.waddr   = 16'h0201;
    bus.wdata   = 32'h2000_0001;
    bus.ram_ack = 1'b1;
    tick();
    bus.we      = 1'b0;
    bus.ram_ack = 1'b0;
    chk("pp_cnt1", 64'(bus.wb_cnt), 64'd1);
    chk("pp_head1", 64'(bus.ram_addr), 64'h0201);
    chk("pp_data1", 64'(bus.ram_wdata), 64'h2000_0001);
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    chk("pp_done", 64'(bus.wb_cnt), 64'd0);

    // Async reset between edges drops pending entries.
    bus.we    = 1'b1;
    bus.waddr = 16'h0300;
    bus.wdata = 32'h3000_0000;
    tick();
    bus.waddr = 16'h0301;
    bus.wdata = 32'h3000_0001;
    tick();
    bus.we = 1'b0;
    chk("ar_pre_cnt", 64'(bus.wb_cnt), 64'd2);
    #2;
    RST_L = 1'b0;
    #1;
    chk("ar_we", 64'(bus.ram_we), 64'd0);
    chk("ar_cnt", 64'(bus.wb_cnt), 64'd0);
    chk("ar_empty", 64'(bus.wb_empty), 64'd1);
    tick();
    RST_L = 1'b1;
    tick();
    bus.we    = 1'b1;
    bus.waddr = 16'h0400;
    bus.wdata = 32'h4000_0000;
    tick();
    bus.we = 1'b0;
    chk("ar_new_we", 64'(bus.ram_we), 64'd1);
    chk("ar_new_addr", 64'(bus.ram_addr), 64'h0400);
    chk("ar_new_data", 64'(bus.ram_wdata), 64'h4000_0000);
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    chk("ar_new_done", 64'(bus.wb_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
